ps2_input_ctrl: RTL and testbench

PS2_INPUT_CTRL -- requirements
Module: ps2_input_ctrl

---
 rtl/ps2_input_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_input_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_input_ctrl.sv
// rtl/ps2_input_ctrl.sv - PS/2 keyboard receiver, game-key decoder and key-event queue
//
// Purpose: receives PS/2 scan-code frames, tracks the held state of five game
// keys (A, D, W, S, SPACE), presents a prioritised game command and queues
// press/release events for a consumer.
//
// Ports:
//   clk, reset          system clock (rising edge), asynchronous active-low reset
//   ps2_clk, ps2_data   raw PS/2 lines, asynchronous to clk
//   keyboard_input      registered prioritised command (0 none .. 5 shoot)
//   held                key-held bitmap {SPACE, S, W, D, A}
//   ev_valid/ev_data    head of the event queue: {press, key id[2:0]}
//   ev_ready            consumer accepts head event
//   frame_err           one-cycle pulse per rejected or aborted frame
//   ev_ovf              sticky: an event was dropped on a full queue
module ps2_input_ctrl #(
    parameter int TIMEOUT    = 12500,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keyboard_input,
    output logic [4:0]  held,
    output logic        ev_valid,
    output logic [3:0]  ev_data,
    input  logic        ev_ready,
    output logic        frame_err,
    output logic        ev_ovf
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // Synchronisers; reset to the idle-high line level so release never fakes an edge.
    logic clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
    logic fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q} <= '1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    // Receiver FSM
    state_t          state_q;
    logic [3:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic [TW-1:0]   tmo_q;
    logic [7:0]      byte_q;
    logic            byte_vld_q;
    logic            frame_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (fall) begin
                        if (!dat_s2_q) begin
                            state_q   <= ST_SHIFT;
                            bit_cnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        tmo_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            // LSB arrives first: shift right, new bit enters at the top
                            shift_q <= {dat_s2_q, shift_q[7:1]};
                        end else if (bit_cnt_q == 4'd8) begin
                            par_q <= dat_s2_q;
                        end else begin
                            state_q <= ST_IDLE;
                            // odd parity: data plus parity bit carry an odd number of ones
                            if (dat_s2_q && (^{shift_q, par_q})) begin
                                byte_q     <= shift_q;
                                byte_vld_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= ST_IDLE;
                        shift_q     <= '0;
                        tmo_q       <= '0;
                        frame_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Decoder
    logic       ext_q, brk_q;
    logic [4:0] held_q;
    logic       key_hit;
    logic [2:0] key_id;
    logic       key_new;
    logic       is_data;
    logic       push;

    always_comb begin
        key_hit = 1'b1;
        key_id  = 3'd0;
        case (byte_q)
            8'h1C:   key_id = 3'd0;
            8'h23:   key_id = 3'd1;
            8'h1D:   key_id = 3'd2;
            8'h1B:   key_id = 3'd3;
            8'h29:   key_id = 3'd4;
            default: key_hit = 1'b0;
        endcase
    end

    assign key_new = ~brk_q;
    assign is_data = byte_vld_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);
    // Only a real change of held state produces an event; typematic repeats do not.
    assign push    = is_data && !ext_q && key_hit && (held_q[key_id] != key_new);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            held_q <= '0;
        end else if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
                if (push) held_q[key_id] <= key_new;
            end
        end
    end

    // Prioritised game command
    logic [15:0] kb_d, kb_q;

    always_comb begin
        kb_d = '0;
        if (held_q[4])      kb_d = 16'd5;
        else if (held_q[2]) kb_d = 16'd3;
        else if (held_q[3]) kb_d = 16'd4;
        else if (held_q[0]) kb_d = 16'd1;
        else if (held_q[1]) kb_d = 16'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) kb_q <= '0;
        else        kb_q <= kb_d;
    end

    // Event queue
    logic [3:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, wr_en;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = ev_valid && ev_ready;
    // A pop on the same cycle frees the slot, so a push into a full queue still lands.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);
        if (push && !wr_en)     ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {key_new, key_id};
    end

    assign ev_valid       = (count_q != '0);
    assign ev_data        = ev_valid ? mem[rd_ptr_q] : 4'd0;
    assign held           = held_q;
    assign keyboard_input = kb_q;
    assign frame_err      = frame_err_q;
    assign ev_ovf         = ovf_q;

endmodule

// File: tb/tb_ps2_input_ctrl.sv
// tb/tb_ps2_input_ctrl.sv - scoreboard testbench for ps2_input_ctrl
module tb_ps2_input_ctrl;

    localparam int TO    = 100;
    localparam int DEPTH = 4;
    localparam int HALF  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ev_ready = 1'b0;
    logic [15:0] keyboard_input;
    logic [4:0]  held;
    logic        ev_valid;
    logic [3:0]  ev_data;
    logic        frame_err;
    logic        ev_ovf;

    ps2_input_ctrl #(.TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .keyboard_input (keyboard_input),
        .held           (held),
        .ev_valid       (ev_valid),
        .ev_data        (ev_data),
        .ev_ready       (ev_ready),
        .frame_err      (frame_err),
        .ev_ovf         (ev_ovf)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] sb[$];
    logic [4:0] m_held = '0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    bit         exp_ovf = 1'b0;
    int         exp_ferr = 0;
    int         ferr_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted event is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_err) ferr_seen++;
            if (ev_valid && ev_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got %0h expected none", ev_data);
                end else begin
                    check("ev_data", int'(ev_data), int'(sb.pop_front()));
                end
            end
        end
    end

    function automatic int key_of(input logic [7:0] b);
        case (b)
            8'h1C:   return 0;
            8'h23:   return 1;
            8'h1D:   return 2;
            8'h1B:   return 3;
            8'h29:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic int kb_model(input logic [4:0] h);
        if (h[4]) return 5;
        if (h[2]) return 3;
        if (h[3]) return 4;
        if (h[0]) return 1;
        if (h[1]) return 2;
        return 0;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit pop_now);
        int  id;
        bit  nv;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            id = key_of(b);
            nv = !m_brk;
            if (!m_ext && id >= 0 && m_held[id] != nv) begin
                m_held[id] = nv;
                if (sb.size() >= DEPTH && !pop_now) exp_ovf = 1'b1;
                else sb.push_back({nv, 3'(id)});
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_now);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (pop_now && i == 10) begin
                // pop lands on the same edge the stop-bit byte is pushed
                wait_cyc(3);
                ev_ready = 1'b1;
                wait_cyc(1);
                ev_ready = 1'b0;
                wait_cyc(HALF - 4);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit pop_now);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        if (bad_par) exp_ferr++;
        else model_byte(b, pop_now);
        send_bits(bits, 11, pop_now);
        wait_cyc(HALF);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_held"}, int'(held), int'(m_held));
        check({tag, "_kb"}, int'(keyboard_input), kb_model(m_held));
        check({tag, "_ovf"}, int'(ev_ovf), int'(exp_ovf));
        check({tag, "_ferr"}, ferr_seen, exp_ferr);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        check("rst_kb", int'(keyboard_input), 0);
        check("rst_held", int'(held), 0);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_data", int'(ev_data), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_ovf", int'(ev_ovf), 0);
        sb.delete();
        m_held = '0;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_ovf = 1'b0;
        exp_ferr = 0;
        ferr_seen = 0;
        reset = 1'b1;
        wait_cyc(3);
    endtask

    task automatic drain(input string tag);
        ev_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) wait_cyc(1);
        wait_cyc(2);
        check({tag, "_drained"}, sb.size(), 0);
        check({tag, "_valid"}, int'(ev_valid), 0);
    endtask

    initial begin
        logic [7:0] codes [5];
        int         r;
        logic [7:0] b;
        codes = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29};

        apply_reset();
        ev_ready = 1'b1;

        send_byte(8'h1C, 0, 0);
        check_state("press_a");
        check("press_a_held_const", int'(held), 5'b00001);
        check("press_a_kb_const", int'(keyboard_input), 1);

        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        check_state("release_a");
        send_byte(8'h1C, 0, 0);
        send_byte(8'h1C, 0, 0);
        check_state("repeat_a");
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);

        send_byte(8'h1D, 0, 0);
        send_byte(8'h29, 0, 0);
        check("w_space_kb", int'(keyboard_input), 5);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h29, 0, 0);
        check("w_only_kb", int'(keyboard_input), 3);
        check_state("w_only");

        send_byte(8'h23, 1, 0);
        check_state("bad_parity");

        exp_ferr++;
        send_bits(11'h7FF, 1, 0);
        wait_cyc(2 * HALF);
        check_state("bad_start");

        send_byte(8'hE0, 0, 0);
        send_byte(8'h1C, 0, 0);
        check_state("extended");

        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       b = codes[r];
            else if (r < 7)  b = 8'hF0;
            else if (r == 7) b = 8'hE0;
            else if (r == 8) b = 8'($urandom_range(0, 255));
            else             b = codes[$urandom_range(0, 4)];
            send_byte(b, r == 9, 0);
            check_state("random");
        end
        drain("random");

        apply_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(codes[i], 0, 0);
        check_state("overflow");
        check("overflow_valid", int'(ev_valid), 1);
        drain("overflow");

        apply_reset();
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(codes[i], 0, 0);
        send_byte(codes[4], 0, 1);
        check_state("full_push_pop");
        drain("full_push_pop");

        apply_reset();
        ev_ready = 1'b1;
        exp_ferr++;
        send_bits(11'b000_0000_0000, 3, 0);
        wait_cyc(TO + 20);
        check_state("timeout");
        send_byte(8'h1B, 0, 0);
        check("after_timeout_held", int'(held), 5'b01000);
        check("after_timeout_kb", int'(keyboard_input), 4);
        check_state("after_timeout");

        send_bits({1'b1, ~^8'h23, 8'h23, 1'b0}, 4, 0);
        apply_reset();
        ev_ready = 1'b1;
        send_byte(8'h1C, 0, 0);
        check_state("after_mid_reset");
        check("after_mid_reset_held", int'(held), 5'b00001);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
